// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared scan-code constants, key-event record and FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] c_code_e0 = 8'hE0;
    localparam logic [7:0] c_code_f0 = 8'hF0;
    localparam logic [7:0] c_code_aa = 8'hAA;
    localparam logic [7:0] c_code_fa = 8'hFA;
    localparam logic [7:0] c_code_fe = 8'hFE;
    localparam logic [7:0] c_code_e1 = 8'hE1;
    localparam logic [7:0] c_code_00 = 8'h00;
    localparam logic [7:0] c_code_ff = 8'hFF;

    localparam int c_event_w = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } ps2_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : First-word-fall-through key-event FIFO with registered head
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  ps2_event_t i_data,
    input  logic       i_pop,
    output logic       o_valid,
    output ps2_event_t o_head,
    output logic       o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ps2_event_t      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_wr_nxt;
    logic [AW:0]     w_rd_nxt;
    logic            w_empty;
    logic            w_full;
    logic            w_do_push;
    logic            w_do_pop;
    ps2_event_t      w_head_nxt;
    logic            r_valid;
    ps2_event_t      r_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_drop    = i_push && w_full && !w_do_pop;
    assign w_wr_nxt  = r_wr_ptr + (AW+1)'(w_do_push);
    assign w_rd_nxt  = r_rd_ptr + (AW+1)'(w_do_pop);

    // Next head bypasses the memory when the write lands on the new read slot
    always_comb begin
        w_head_nxt = '0;
        if (w_wr_nxt != w_rd_nxt) begin
            if (w_do_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]))
                w_head_nxt = i_data;
            else
                w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            r_head   <= w_head_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_head;

endmodule

`default_nettype wire

// File: rtl/ps2_scan_sequencer.sv
// ============================================================================
//  Module      : ps2_scan_sequencer
//  Description : PS/2 scan-code handshake, prefix folding and event buffering
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    output logic       read,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       bat_ok,
    output logic       kb_error,
    output logic       ev_overflow,
    input  logic       clr_status
);

    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rdy_s;
    ps2_state_t             r_state;
    ps2_state_t             w_state_nxt;
    logic                   w_capture;
    logic                   w_read;
    logic                   w_is_key;
    logic                   w_is_err;
    logic                   w_push;
    logic                   w_drop;
    ps2_event_t             w_push_ev;
    ps2_event_t             w_head;
    logic                   r_ext_pend;
    logic                   r_brk_pend;
    logic [c_tmo_w-1:0]     r_tmo_cnt;
    logic                   r_bat_ok;
    logic                   r_kb_error;
    logic                   r_overflow;

    assign w_rdy_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], scan_ready};
            r_state <= w_state_nxt;
        end
    end

    // WAIT_LOW holds off until the receiver drops scan_ready, so one code is consumed once
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_read      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rdy_s) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_read      = 1'b1;
                w_state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!w_rdy_s)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_is_err = (scan_code == c_code_00) || (scan_code == c_code_ff);
        w_is_key = 1'b1;
        case (scan_code)
            c_code_e0, c_code_f0, c_code_aa, c_code_00, c_code_ff,
            c_code_fa, c_code_fe, c_code_e1: w_is_key = 1'b0;
            default:                         w_is_key = 1'b1;
        endcase
    end

    assign w_push    = w_capture && w_is_key;
    assign w_push_ev = '{ext: r_ext_pend, brk: r_brk_pend, code: scan_code};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_tmo_cnt  <= '0;
            r_bat_ok   <= 1'b0;
            r_kb_error <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_bat_ok <= w_capture && (scan_code == c_code_aa);
            if (w_capture) begin
                r_tmo_cnt <= '0;
                case (scan_code)
                    c_code_e0:                       r_ext_pend <= 1'b1;
                    c_code_f0:                       r_brk_pend <= 1'b1;
                    c_code_fa, c_code_fe, c_code_e1: ;
                    default: begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                    end
                endcase
            end else if (r_ext_pend || r_brk_pend) begin
                if (r_tmo_cnt == c_tmo_last) begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    r_tmo_cnt  <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
                end
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_capture && w_is_err)
                r_kb_error <= 1'b1;
            else if (clr_status)
                r_kb_error <= 1'b0;

            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_status)
                r_overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (ev_ready),
        .o_valid (ev_valid),
        .o_head  (w_head),
        .o_drop  (w_drop)
    );

    assign read        = w_read;
    assign ev_code     = w_head.code;
    assign ev_ext      = w_head.ext;
    assign ev_break    = w_head.brk;
    assign bat_ok      = r_bat_ok;
    assign kb_error    = r_kb_error;
    assign ev_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
// ============================================================================
//  Module      : tb_ps2_scan_sequencer
//  Description : Directed, table-driven bench for ps2_scan_sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scan_sequencer;

    localparam int c_depth = 8;
    localparam int c_tmo   = 200;
    localparam int c_sync  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       read;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       bat_ok;
    logic       kb_error;
    logic       ev_overflow;
    logic       clr_status;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        int         n;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       has_ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        int         bats;
        logic       err;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   read_cnt = 0;
    int   bat_cnt  = 0;
    ev_t  evq[$];
    vec_t vecs[10];

    ps2_scan_sequencer #(
        .FIFO_DEPTH  (c_depth),
        .TIMEOUT_CYC (c_tmo),
        .SYNC_STAGES (c_sync)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .scan_ready  (scan_ready),
        .scan_code   (scan_code),
        .read        (read),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_break    (ev_break),
        .bat_ok      (bat_ok),
        .kb_error    (kb_error),
        .ev_overflow (ev_overflow),
        .clr_status  (clr_status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (read)
                read_cnt++;
            if (bat_ok)
                bat_cnt++;
            if (ev_valid && ev_ready)
                evq.push_back({ev_ext, ev_break, ev_code});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise scan_ready, wait for the ack pulse, drop it and let the FSM return to IDLE
    task automatic send_code(input logic [7:0] c);
        bit seen;
        seen       = 1'b0;
        scan_code  = c;
        scan_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (read) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            chk("read_wait_bound", 32'd0, 32'd1);
        scan_ready = 1'b0;
        tick(6);
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] cs[3];
        int         k;

        reset      = 1'b1;
        scan_ready = 1'b0;
        scan_code  = 8'h00;
        ev_ready   = 1'b1;
        clr_status = 1'b0;
        #1;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_status", {29'd0, bat_ok, kb_error, ev_overflow}, 32'd0);
        chk("rst_head", {22'd0, ev_ext, ev_break, ev_code}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Latency of a single make code, with the head held by ev_ready=0
        ev_ready   = 1'b0;
        scan_code  = 8'h1C;
        scan_ready = 1'b1;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (ev_valid) begin
                k = i;
                break;
            end
        end
        chk("lat_ev_valid", 32'(k), 32'(c_sync + 1));
        chk("lat_read", 32'(read), 32'd1);
        chk("lat_head", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, 2'b00, 8'h1C});
        scan_ready = 1'b0;
        ev_ready   = 1'b1;
        tick(6);
        chk("lat_ev_drained", 32'(ev_valid), 32'd0);
        evq.delete();

        vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{2, 8'hF0, 8'h1C, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b1, 0, 1'b0};
        vecs[2] = '{3, 8'hE0, 8'hF0, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 0, 1'b0};
        vecs[3] = '{2, 8'hE0, 8'h75, 8'h00, 1'b1, 8'h75, 1'b1, 1'b0, 0, 1'b0};
        vecs[4] = '{3, 8'hF0, 8'hFA, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 0, 1'b0};
        vecs[5] = '{3, 8'hE0, 8'hE1, 8'h74, 1'b1, 8'h74, 1'b1, 1'b0, 0, 1'b0};
        vecs[6] = '{2, 8'hAA, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1};
        vecs[7] = '{3, 8'hE0, 8'h00, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 0, 1'b1};
        vecs[8] = '{3, 8'hF0, 8'hAA, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0};
        vecs[9] = '{3, 8'hE0, 8'hFE, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1};

        for (int v = 0; v < 10; v++) begin
            evq.delete();
            bat_cnt = 0;
            cs = '{vecs[v].c0, vecs[v].c1, vecs[v].c2};
            for (int j = 0; j < vecs[v].n; j++)
                send_code(cs[j]);
            chk($sformatf("vec%0d_ev_count", v), 32'(evq.size()), 32'(vecs[v].has_ev));
            if (vecs[v].has_ev && evq.size() > 0)
                chk($sformatf("vec%0d_event", v), {22'd0, evq[0]},
                    {22'd0, vecs[v].ext, vecs[v].brk, vecs[v].code});
            chk($sformatf("vec%0d_bat_ok", v), 32'(bat_cnt), 32'(vecs[v].bats));
            chk($sformatf("vec%0d_kb_error", v), 32'(kb_error), 32'(vecs[v].err));
            pulse_clr();
        end
        chk("kb_error_cleared", 32'(kb_error), 32'd0);

        // A lone E0 expires before the next key arrives
        evq.delete();
        send_code(8'hE0);
        tick(c_tmo + 10);
        send_code(8'h75);
        chk("tmo_ev_count", 32'(evq.size()), 32'd1);
        if (evq.size() > 0)
            chk("tmo_event", {22'd0, evq[0]}, {22'd0, 2'b00, 8'h75});

        // scan_ready stuck high is consumed exactly once
        evq.delete();
        read_cnt   = 0;
        scan_code  = 8'h2C;
        scan_ready = 1'b1;
        tick(100);
        scan_ready = 1'b0;
        tick(6);
        chk("hold_read_count", 32'(read_cnt), 32'd1);
        chk("hold_ev_count", 32'(evq.size()), 32'd1);

        // Nine makes into an eight-deep FIFO with the consumer stalled
        evq.delete();
        ev_ready = 1'b0;
        for (int j = 0; j < c_depth; j++)
            send_code(8'h10 + 8'(j));
        chk("ovf_not_yet", 32'(ev_overflow), 32'd0);
        send_code(8'h10 + 8'(c_depth));
        chk("ovf_set", 32'(ev_overflow), 32'd1);
        ev_ready = 1'b1;
        tick(c_depth + 4);
        chk("ovf_ev_count", 32'(evq.size()), 32'(c_depth));
        for (int j = 0; j < c_depth && j < evq.size(); j++)
            chk($sformatf("ovf_order%0d", j), {22'd0, evq[j]}, {22'd0, 2'b00, 8'h10 + 8'(j)});
        chk("ovf_sticky", 32'(ev_overflow), 32'd1);
        pulse_clr();
        chk("ovf_cleared", 32'(ev_overflow), 32'd0);

        // Reset lands while read is high; the still-raised code is taken once afterwards
        evq.delete();
        scan_code  = 8'h33;
        scan_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (read) begin
                k = 1;
                break;
            end
        end
        chk("rstack_reached_ack", 32'(k), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstack_read", 32'(read), 32'd0);
        chk("rstack_ev_valid", 32'(ev_valid), 32'd0);
        tick(2);
        evq.delete();
        read_cnt = 0;
        reset    = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (read) begin
                k = 1;
                break;
            end
        end
        chk("rstack_reack", 32'(k), 32'd1);
        scan_ready = 1'b0;
        tick(6);
        chk("rstack_read_count", 32'(read_cnt), 32'd1);
        chk("rstack_ev_count", 32'(evq.size()), 32'd1);
        if (evq.size() > 0)
            chk("rstack_event", {22'd0, evq[0]}, {22'd0, 2'b00, 8'h33});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
